multimode_ring_counter: RTL

//  Parametrised one-hot/twisted-ring pattern counter for LED/scan-strobe generation.

---
 rtl/multimode_ring_counter_pkg.sv | 19 +
 rtl/multimode_ring_counter_div.sv | 31 +++
 rtl/multimode_ring_counter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/multimode_ring_counter_pkg.sv
// Shared encodings for the multimode ring counter.
// Mode and direction codes plus prescaler width helper.
package multimode_ring_counter_pkg;

   typedef enum logic [1:0] {
      MODE_RING    = 2'b00,
      MODE_JOHNSON = 2'b01,
      MODE_BOUNCE  = 2'b10,
      MODE_HOLD    = 2'b11
   } mode_t;

   localparam logic DIR_RIGHT = 1'b0;
   localparam logic DIR_LEFT  = 1'b1;

   function automatic int cnt_width(input int prescale);
      return (prescale > 1) ? $clog2(prescale) : 1;
   endfunction

endpackage

// File: rtl/multimode_ring_counter_div.sv
// Prescaler producing a single-cycle step strobe.
// Counter restarts from zero on clr or sync_zero.
import multimode_ring_counter_pkg::*;

module clk_enable_div #(
   parameter int PRESCALE = 67108864
) (
   input  logic clk,
   input  logic clr,
   input  logic en,
   input  logic sync_zero,
   output logic tick
);

   localparam int CW = cnt_width(PRESCALE);
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] cnt;

   // a restart in the step cycle swallows that step
   assign tick = en && (cnt == LAST) && !clr && !sync_zero;

   always_ff @(posedge clk) begin
      if (clr || sync_zero) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: rtl/multimode_ring_counter.sv
// Ring / Johnson / bounce / hold pattern counter with
// parallel load and one-hot self-correction.
import multimode_ring_counter_pkg::*;

module multimode_ring_counter #(
   parameter int                WIDTH    = 4,
   parameter int                PRESCALE = 67108864,
   parameter logic [WIDTH-1:0]  INIT     = {1'b1, {(WIDTH-1){1'b0}}}
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             tick,
   output logic             wrap,
   output logic             err
);

   logic             step;
   logic             bdir;
   logic             legal;
   logic             moved;
   logic [WIDTH-1:0] nq;
   logic             nbdir;
   logic             nwrap;
   logic             nerr;

   clk_enable_div #(
      .PRESCALE (PRESCALE)
   ) u_div (
      .clk       (clk),
      .clr       (clr),
      .en        (en),
      .sync_zero (load),
      .tick      (step)
   );

   assign legal = (q != '0) && ((q & (q - WIDTH'(1))) == '0);

   always_comb begin
      nq    = q;
      nbdir = bdir;
      nerr  = 1'b0;
      moved = 1'b0;
      unique case (mode_t'(mode))
         MODE_RING: begin
            if (!legal) begin
               nq   = INIT;
               nerr = 1'b1;
            end else begin
               moved = 1'b1;
               if (dir == DIR_LEFT) nq = {q[WIDTH-2:0], q[WIDTH-1]};
               else                 nq = {q[0], q[WIDTH-1:1]};
            end
         end
         MODE_JOHNSON: begin
            moved = 1'b1;
            if (dir == DIR_LEFT) nq = {q[WIDTH-2:0], ~q[WIDTH-1]};
            else                 nq = {~q[0], q[WIDTH-1:1]};
         end
         MODE_BOUNCE: begin
            if (!legal) begin
               nq   = INIT;
               nerr = 1'b1;
            end else begin
               moved = 1'b1;
               // reaching an end bit reverses and steps back in one go
               if (bdir == DIR_RIGHT) begin
                  if (q[0]) begin
                     nbdir = DIR_LEFT;
                     nq    = q << 1;
                  end else begin
                     nq = q >> 1;
                  end
               end else begin
                  if (q[WIDTH-1]) begin
                     nbdir = DIR_RIGHT;
                     nq    = q >> 1;
                  end else begin
                     nq = q << 1;
                  end
               end
            end
         end
         MODE_HOLD: begin
            nq = q;
         end
      endcase
      nwrap = moved && (nq == INIT);
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         q    <= INIT;
         bdir <= dir;
         tick <= 1'b0;
         wrap <= 1'b0;
         err  <= 1'b0;
      end else if (load) begin
         q    <= load_val;
         bdir <= dir;
         tick <= 1'b0;
         wrap <= 1'b0;
         err  <= 1'b0;
      end else begin
         tick <= step;
         wrap <= step && nwrap;
         err  <= step && nerr;
         if (step) begin
            q    <= nq;
            bdir <= nbdir;
         end
      end
   end

endmodule
